bkm_step_scoreboard: RTL and testbench
======================================

Name: bkm_step_scoreboard

Overview:
- Parametrised in-order scoreboard for the BKM data-step datapath, instantiated in the xfire_fpu_bkm verification bench.
- Queues expected complex step results (X, Y) from the reference model and compares them, in order, against DUT step results.
- Keeps saturating match/error counters, captures the first failing transaction index, and flags queue overflow/underflow.
- Successor to the single-step checker: configurable data width, queue depth, stop-on-error mode and optional LSB tolerance.

Parameters:
- W, 32, width of each X/Y component (two's complement).
- DEPTH, 8, expected-value queue depth; power of two, 2..64.
- CNT_W, 16, width of the counters and the index.
- STOP_ON_ERR, 0, 1 = freeze counters after the first mismatch.
- TOL, 1, absolute tolerance in LSBs per component; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- srst  in  1  synchronous clear, active high; same effect as reset.
- enable  in  1  when low, no push, pop or state update occurs; everything holds.
- exp_valid  in  1  expected-result push strobe.
- exp_x, exp_y  in  W each  expected result.
- dut_valid  in  1  DUT-result strobe.
- dut_x, dut_y  in  W each  DUT result.
- fifo_level  out  $clog2(DEPTH)+1  current queue occupancy.
- cmp_count  out  CNT_W  number of comparisons performed.
- err_count  out  CNT_W  number of mismatches.
- first_err_idx  out  CNT_W  cmp_count value of the first mismatch.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: DUT result arrived while empty.
- fail  out  1  sticky summary flag.

Behaviour:
- Reset values (arst_n low, or srst high on an edge): all outputs 0, queue empty, state IDLE.
- Push: enable && exp_valid. Pop: enable && dut_valid.
- The queue is a circular buffer. Read and write pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Full and push without pop: the push is dropped, overflow is set, and the level is unchanged.
- Full with push and pop together: both take effect and the level is unchanged.
- Empty and pop: there is no bypass, even if a push happens in the same cycle. underflow is set, no comparison occurs, and any push still lands.
- Valid pop: the head entry and DUT data are registered into a compare stage (1 cycle).
  - The counters update on the following edge, so cmp_count/err_count latency is 2 edges from the dut_valid edge.
  - fifo_level updates after 1 edge.
- Compare result:
  - cmp_count increments on every compare.
  - err_count increments on a mismatch.
  - On the first mismatch, first_err_idx is loaded with the pre-increment cmp_count.
- Both counters saturate at all-ones, and there is no wrap.
- FSM states:
  - IDLE: no compare yet. Moves to RUN on the first compare, or directly to FAIL if that compare mismatches and STOP_ON_ERR=1.
  - RUN: comparisons active. On a mismatch: goes to FAIL if STOP_ON_ERR=1, otherwise stays in RUN.
  - FAIL: terminal until reset. cmp_count, err_count and first_err_idx are frozen. The queue keeps pushing and popping, and the overflow/underflow flags still update.
- fail = (err_count != 0) || overflow || underflow, registered, so it rises 1 edge after its cause.
- A reset in the middle of a pending compare discards that compare.

Optional Feature:
- Macro: BKM_SCOREBOARD_TOL_EN.
- Defined: a component matches when |dut - exp| <= TOL.
  - The difference is computed sign-extended to W+1 bits and its magnitude is taken in W+1 bits, so the most-negative difference does not overflow.
  - Both components must match.
- Undefined: exact bitwise equality on both components; TOL is ignored and its logic is not synthesised.

Test Plan:
- W=16, DEPTH=4: push 3 values, then pop 3 equal DUT values → cmp_count=3, err_count=0, fail=0, fifo_level returns to 0.
- STOP_ON_ERR=0: 4 compares, mismatch on the 2nd (exp_x=0x0010, dut_x=0x0011, no TOL_EN) → err_count=1, first_err_idx=1, cmp_count=4, fail=1.
- STOP_ON_ERR=1: same stream as above → cmp_count=2, err_count=1, and no further counter change after the freeze.
- Push 5 values into DEPTH=4 → overflow=1, fifo_level=4. Then push and pop in the same cycle while full → level stays 4 and overflow stays 1.
- dut_valid with the queue empty, together with exp_valid → underflow=1, no compare, fifo_level=1.
- With BKM_SCOREBOARD_TOL_EN, TOL=1:
  - exp 0x7FFF vs dut 0x7FFE → match.
  - exp 0x8000 vs dut 0x7FFF → mismatch (no wrap).
  - Assert arst_n low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/bkm_step_scoreboard.sv
// In-order scoreboard comparing queued expected BKM step results (X, Y) against DUT results.
// Define BKM_SCOREBOARD_TOL_EN to accept per-component differences up to +/-TOL LSBs.
module bkm_step_scoreboard #(
    parameter int W           = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0,
    parameter int TOL         = 1
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   srst,
    input  logic                   enable,
    input  logic                   exp_valid,
    input  logic [W-1:0]           exp_x,
    input  logic [W-1:0]           exp_y,
    input  logic                   dut_valid,
    input  logic [W-1:0]           dut_x,
    input  logic [W-1:0]           dut_y,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       cmp_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       first_err_idx,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TOL < 0) begin : g_bad_params
        $error("bkm_step_scoreboard: DEPTH must be a power of two in 2..64 and TOL >= 0");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef BKM_SCOREBOARD_TOL_EN
    // Difference and magnitude in W+1 bits so the most-negative difference cannot wrap.
    function automatic logic comp_match(input logic [W-1:0] e, input logic [W-1:0] d);
        logic signed [W:0] diff;
        logic        [W:0] mag;
        diff = $signed({d[W-1], d}) - $signed({e[W-1], e});
        mag  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        return mag <= (W+1)'(TOL);
    endfunction
`else
    function automatic logic comp_match(input logic [W-1:0] e, input logic [W-1:0] d);
        return d == e;
    endfunction
`endif

    logic [2*W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            cmp_vld_p1_q, cmp_vld_p1_d;
    logic [W-1:0]    exp_x_p1_q, exp_y_p1_q, dut_x_p1_q, dut_y_p1_q;
    logic [CNT_W-1:0] cmp_count_q, cmp_count_d, err_count_q, err_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic            overflow_q, overflow_d, underflow_q, underflow_d, fail_q, fail_d;
    state_t          state_q, state_d;

    logic [PW-1:0]   level;
    logic            full, empty, push_req, pop_req, push_ok, pop_ok, cmp_match_p1;
    logic [2*W-1:0]  head;

    assign level        = wr_ptr_q - rd_ptr_q;
    assign full         = (level == PW'(DEPTH));
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign push_req     = enable && exp_valid;
    assign pop_req      = enable && dut_valid;
    assign pop_ok       = pop_req && !empty;
    assign push_ok      = push_req && (!full || pop_ok);
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign cmp_match_p1 = comp_match(exp_x_p1_q, dut_x_p1_q) && comp_match(exp_y_p1_q, dut_y_p1_q);

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        cmp_vld_p1_d    = cmp_vld_p1_q;
        cmp_count_d     = cmp_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        overflow_d      = overflow_q;
        underflow_d     = underflow_q;
        state_d         = state_q;
        fail_d          = (err_count_q != '0) || overflow_q || underflow_q;
        if (srst) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            cmp_vld_p1_d    = 1'b0;
            cmp_count_d     = '0;
            err_count_d     = '0;
            first_err_idx_d = '0;
            overflow_d      = 1'b0;
            underflow_d     = 1'b0;
            state_d         = S_IDLE;
            fail_d          = 1'b0;
        end else if (enable) begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            cmp_vld_p1_d = pop_ok;
            if (push_req && full && !pop_ok) overflow_d = 1'b1;
            if (pop_req && empty)            underflow_d = 1'b1;
            // Counters and first index stay frozen once the FSM has reached FAIL.
            if (cmp_vld_p1_q && state_q != S_FAIL) begin
                cmp_count_d = sat_inc(cmp_count_q);
                state_d     = S_RUN;
                if (!cmp_match_p1) begin
                    err_count_d = sat_inc(err_count_q);
                    if (err_count_q == '0) first_err_idx_d = cmp_count_q;
                    if (STOP_ON_ERR) state_d = S_FAIL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cmp_vld_p1_q    <= 1'b0;
            cmp_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            state_q         <= S_IDLE;
            fail_q          <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cmp_vld_p1_q    <= cmp_vld_p1_d;
            cmp_count_q     <= cmp_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            state_q         <= state_d;
            fail_q          <= fail_d;
        end
    end

    // Queue storage and compare-stage data carry no reset; the pointers and valid qualify them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {exp_x, exp_y};
        if (pop_ok) begin
            exp_x_p1_q <= head[2*W-1:W];
            exp_y_p1_q <= head[W-1:0];
            dut_x_p1_q <= dut_x;
            dut_y_p1_q <= dut_y;
        end
    end

    assign fifo_level    = level;
    assign cmp_count     = cmp_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign fail          = fail_q;

endmodule

// File: tb/tb_bkm_step_scoreboard.sv
// Directed bench for bkm_step_scoreboard: two instances (STOP_ON_ERR 0 and 1) share one stimulus stream.
module tb_bkm_step_scoreboard;

    logic        clk = 1'b0;
    logic        arst_n, srst, enable, exp_valid, dut_valid;
    logic [15:0] exp_x, exp_y, dut_x, dut_y;

    logic [2:0]  lvl_a, lvl_b;
    logic [15:0] cmp_a, err_a, idx_a, cmp_b, err_b, idx_b;
    logic        ovf_a, udf_a, fail_a, ovf_b, udf_b, fail_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bkm_step_scoreboard #(.W(16), .DEPTH(4), .CNT_W(16), .STOP_ON_ERR(1'b0), .TOL(1)) u_run (
        .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
        .exp_valid(exp_valid), .exp_x(exp_x), .exp_y(exp_y),
        .dut_valid(dut_valid), .dut_x(dut_x), .dut_y(dut_y),
        .fifo_level(lvl_a), .cmp_count(cmp_a), .err_count(err_a), .first_err_idx(idx_a),
        .overflow(ovf_a), .underflow(udf_a), .fail(fail_a)
    );

    bkm_step_scoreboard #(.W(16), .DEPTH(4), .CNT_W(16), .STOP_ON_ERR(1'b1), .TOL(1)) u_stop (
        .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
        .exp_valid(exp_valid), .exp_x(exp_x), .exp_y(exp_y),
        .dut_valid(dut_valid), .dut_x(dut_x), .dut_y(dut_y),
        .fifo_level(lvl_b), .cmp_count(cmp_b), .err_count(err_b), .first_err_idx(idx_b),
        .overflow(ovf_b), .underflow(udf_b), .fail(fail_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [15:0] ex, input logic [15:0] ey,
                         input logic dv, input logic [15:0] dx, input logic [15:0] dy);
        exp_valid = ev; exp_x = ex; exp_y = ey;
        dut_valid = dv; dut_x = dx; dut_y = dy;
        step(1);
        exp_valid = 1'b0;
        dut_valid = 1'b0;
    endtask

    task automatic push(input logic [15:0] ex, input logic [15:0] ey);
        drive(1'b1, ex, ey, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic pop(input logic [15:0] dx, input logic [15:0] dy);
        drive(1'b0, 16'h0, 16'h0, 1'b1, dx, dy);
    endtask

    task automatic sync_clear();
        srst = 1'b1;
        step(1);
        srst = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; srst = 1'b0; enable = 1'b1;
        exp_valid = 1'b0; dut_valid = 1'b0;
        exp_x = '0; exp_y = '0; dut_x = '0; dut_y = '0;
        #12;
        chk("rst_level", 32'(lvl_a), 0);
        chk("rst_cmp", 32'(cmp_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_flags", 32'({ovf_a, udf_a, fail_a, ovf_b, udf_b, fail_b}), 0);
        step(1);
        arst_n = 1'b1;

        // Three matching transactions
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        chk("t1_level_full3", 32'(lvl_a), 3);
        pop(16'h1111, 16'h2222);
        pop(16'h3333, 16'h4444);
        pop(16'h5555, 16'h6666);
        chk("t1_level_drained", 32'(lvl_a), 0);
        step(2);
        chk("t1_cmp", 32'(cmp_a), 3);
        chk("t1_err", 32'(err_a), 0);
        chk("t1_fail", 32'(fail_a), 0);
        chk("t1_cmp_stop", 32'(cmp_b), 3);
        sync_clear();
        chk("srst_cmp", 32'(cmp_a), 0);

        // Mismatch on the second of four compares
        push(16'h0001, 16'h0101);
        push(16'h0010, 16'h0202);
        push(16'h0003, 16'h0303);
        push(16'h0004, 16'h0404);
        pop(16'h0001, 16'h0101);
        pop(16'h0011, 16'h0202);
        pop(16'h0003, 16'h0303);
        pop(16'h0004, 16'h0404);
        step(2);
        chk("t2_run_cmp", 32'(cmp_a), 4);
        chk("t2_run_err", 32'(err_a), 1);
        chk("t2_run_idx", 32'(idx_a), 1);
        chk("t2_run_fail", 32'(fail_a), 1);
        chk("t2_stop_cmp", 32'(cmp_b), 2);
        chk("t2_stop_err", 32'(err_b), 1);
        chk("t2_stop_idx", 32'(idx_b), 1);
        chk("t2_stop_fail", 32'(fail_b), 1);
        push(16'h0009, 16'h0000);
        pop(16'h000A, 16'h0000);
        step(2);
        chk("t2_run_cmp2", 32'(cmp_a), 5);
        chk("t2_run_err2", 32'(err_a), 2);
        chk("t2_run_idx2", 32'(idx_a), 1);
        chk("t2_stop_frozen", 32'({cmp_b, err_b}), 32'h0002_0001);
        chk("t2_stop_level", 32'(lvl_b), 0);
        sync_clear();

        // Overflow, then simultaneous push/pop while full
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        chk("t3_level4", 32'(lvl_a), 4);
        chk("t3_no_ovf_yet", 32'(ovf_a), 0);
        push(16'h0104, 16'h0204);
        chk("t3_level_after_drop", 32'(lvl_a), 4);
        chk("t3_ovf", 32'(ovf_a), 1);
        drive(1'b1, 16'h0AAA, 16'h0BBB, 1'b1, 16'h0100, 16'h0200);
        chk("t3_level_pushpop", 32'(lvl_a), 4);
        chk("t3_ovf_sticky", 32'(ovf_a), 1);
        pop(16'h0101, 16'h0201);
        pop(16'h0102, 16'h0202);
        pop(16'h0103, 16'h0203);
        pop(16'h0AAA, 16'h0BBB);
        step(2);
        chk("t3_level_drained", 32'(lvl_a), 0);
        chk("t3_cmp", 32'(cmp_a), 5);
        chk("t3_err", 32'(err_a), 0);
        chk("t3_fail", 32'({fail_a, udf_a}), 2);
        sync_clear();

        // Pop while empty with a simultaneous push
        drive(1'b1, 16'h1234, 16'h5678, 1'b1, 16'h1234, 16'h5678);
        chk("t4_udf", 32'(udf_a), 1);
        chk("t4_level", 32'(lvl_a), 1);
        step(2);
        chk("t4_no_cmp", 32'(cmp_a), 0);
        chk("t4_fail", 32'(fail_a), 1);
        pop(16'h1234, 16'h5678);
        step(2);
        chk("t4_cmp_after", 32'({cmp_a, err_a}), 32'h0001_0000);
        sync_clear();

        // Tolerance boundaries at the positive/negative extremes
        push(16'h7FFF, 16'h0000);
        push(16'h8000, 16'h0000);
        pop(16'h7FFE, 16'h0000);
        pop(16'h7FFF, 16'h0000);
        step(2);
`ifdef BKM_SCOREBOARD_TOL_EN
        chk("t5_run_cmp", 32'(cmp_a), 2);
        chk("t5_run_err", 32'(err_a), 1);
        chk("t5_run_idx", 32'(idx_a), 1);
        chk("t5_stop", 32'({cmp_b, err_b}), 32'h0002_0001);
`else
        chk("t5_run_cmp", 32'(cmp_a), 2);
        chk("t5_run_err", 32'(err_a), 2);
        chk("t5_run_idx", 32'(idx_a), 0);
        chk("t5_stop", 32'({cmp_b, err_b}), 32'h0001_0001);
`endif
        chk("t5_fail", 32'(fail_a), 1);

        // Asynchronous reset with a compare in flight
        push(16'h0042, 16'h0000);
        pop(16'h0042, 16'h0000);
        arst_n = 1'b0;
        #2;
        chk("t6_async_level", 32'(lvl_a), 0);
        chk("t6_async_cnt", 32'({cmp_a, err_a}), 0);
        chk("t6_async_idx", 32'(idx_a), 0);
        chk("t6_async_flags", 32'({ovf_a, udf_a, fail_a, fail_b}), 0);
        #2;
        arst_n = 1'b1;
        step(2);
        chk("t6_discarded", 32'(cmp_a), 0);

        // Enable low holds everything
        enable = 1'b0;
        push(16'h0001, 16'h0000);
        chk("t7_hold_level", 32'(lvl_a), 0);
        enable = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
